pipe_if: RTL and testbench

PIPE_IF -- requirements
Module: pipe_if

---
 rtl/pipe_if.sv | 81 ++++++++
 tb/tb_pipe_if.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipe_if.sv
// Instruction fetch stage: issues imem reads, tracks the IF instruction, holds
// the returned word across ID stalls, and handles branch/flush redirects.
module pipe_if #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] EX_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ex_flush,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  input  logic        hlt,
  input  logic [31:0] imem_rdata,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  output logic        if_id_validto,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc_if;
  logic        r_if_valid;
  logic        r_hold_valid;
  logic [31:0] r_hold_instr;

  logic        w_flush;
  logic        w_if_allowin;
  logic        w_issue;
  logic        w_slot_redirect;
  logic [31:0] w_issue_addr;

  assign w_flush      = ex_flush || eret_flush;
  assign w_if_allowin = !r_if_valid || id_allowin;
  assign w_issue      = !rst && ((w_if_allowin && !hlt) || w_flush);

  // Branch resolved before its delay slot was fetched: fetch the slot now,
  // and steer the following fetch to the target.
  assign w_slot_redirect = br_taken && !r_if_valid && !w_flush;

  always_comb begin
    w_issue_addr = r_fetch_pc;
    if (ex_flush)                    w_issue_addr = EX_VECTOR;
    else if (eret_flush)             w_issue_addr = epc;
    else if (br_taken && r_if_valid) w_issue_addr = br_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_pc_if      <= 32'd0;
      r_if_valid   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'd0;
    end else if (w_issue) begin
      r_pc_if      <= w_issue_addr;
      r_if_valid   <= 1'b1;
      r_hold_valid <= 1'b0;
      r_fetch_pc   <= w_slot_redirect ? br_target : w_issue_addr + 32'd4;
    end else begin
      if (br_taken) r_fetch_pc <= br_target;
      if (r_if_valid && id_allowin) begin
        r_if_valid <= 1'b0;
      end else if (r_if_valid && !r_hold_valid) begin
        // imem data is only guaranteed the cycle after issue; latch it for the stall
        r_hold_instr <= imem_rdata;
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign imem_en       = w_issue;
  assign imem_addr     = w_issue_addr;
  assign if_id_validto = r_if_valid && !w_flush && !rst;
  assign pc_out        = r_pc_if;
  assign instr_out     = (r_hold_valid && !rst) ? r_hold_instr : imem_rdata;

endmodule

// File: tb/tb_pipe_if.sv
// Directed vector bench for pipe_if: a cycle table plus hand-built stall/halt/eret sequences.
module tb_pipe_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        ex_flush = 1'b0;
  logic        eret_flush = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        hlt = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic        if_id_validto;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_if dut (
    .clk(clk), .rst(rst), .id_allowin(id_allowin), .br_taken(br_taken),
    .br_target(br_target), .ex_flush(ex_flush), .eret_flush(eret_flush),
    .epc(epc), .hlt(hlt), .imem_rdata(imem_rdata), .imem_en(imem_en),
    .imem_addr(imem_addr), .if_id_validto(if_id_validto), .pc_out(pc_out),
    .instr_out(instr_out)
  );

  typedef struct {
    logic        rst, id, br;
    logic [31:0] tgt;
    logic        exf, eret;
    logic [31:0] epc;
    logic        hlt;
    logic [31:0] rdata;
    logic [4:0]  mask;  // {en, addr, vld, pc, instr}
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  localparam logic [4:0] M   = 5'h1F;
  localparam logic [4:0] MNA = 5'h17;

  function automatic vec_t v(logic r, logic id, logic br, logic [31:0] tgt,
                             logic exf, logic er, logic [31:0] e, logic h,
                             logic [31:0] rd, logic [4:0] m, logic en,
                             logic [31:0] a, logic vl, logic [31:0] pc,
                             logic [31:0] ins);
    vec_t t;
    t.rst = r; t.id = id; t.br = br; t.tgt = tgt; t.exf = exf; t.eret = er;
    t.epc = e; t.hlt = h; t.rdata = rd; t.mask = m; t.en = en; t.addr = a;
    t.vld = vl; t.pc = pc; t.instr = ins;
    return t;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
  task automatic apply(vec_t t, int idx);
    @(negedge clk);
    rst = t.rst; id_allowin = t.id; br_taken = t.br; br_target = t.tgt;
    ex_flush = t.exf; eret_flush = t.eret; epc = t.epc; hlt = t.hlt;
    imem_rdata = t.rdata;
    #1;
    if (t.mask[4]) chk("imem_en",       idx, {31'd0, imem_en},       {31'd0, t.en});
    if (t.mask[3]) chk("imem_addr",     idx, imem_addr,              t.addr);
    if (t.mask[2]) chk("if_id_validto", idx, {31'd0, if_id_validto}, {31'd0, t.vld});
    if (t.mask[1]) chk("pc_out",        idx, pc_out,                 t.pc);
    if (t.mask[0]) chk("instr_out",     idx, instr_out,              t.instr);
  endtask

  vec_t tbl[21];

  initial begin
    vec_t t;
    logic [31:0] r;
    //            rst id br tgt           exf er epc    hlt rdata         mask en addr          vld pc            instr
    tbl[0]  = v(1, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'hDEAD0000, M,   0, 32'h00400000, 0, 32'h0,        32'hDEAD0000);
    tbl[1]  = v(1, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h11111111, M,   0, 32'h00400000, 0, 32'h0,        32'h11111111);
    tbl[2]  = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h00000000, M,   1, 32'h00400000, 0, 32'h0,        32'h00000000);
    tbl[3]  = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h24010001, M,   1, 32'h00400004, 1, 32'h00400000, 32'h24010001);
    tbl[4]  = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h24020002, M,   1, 32'h00400008, 1, 32'h00400004, 32'h24020002);
    tbl[5]  = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h8C010000, M,   0, 32'h0040000C, 1, 32'h00400008, 32'h8C010000);
    tbl[6]  = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'hFFFFFFFF, M,   0, 32'h0040000C, 1, 32'h00400008, 32'h8C010000);
    tbl[7]  = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h00000000, M,   0, 32'h0040000C, 1, 32'h00400008, 32'h8C010000);
    tbl[8]  = v(0, 1, 1, 32'h00400100,  0, 0, 32'h0, 0, 32'h55555555, M,   1, 32'h00400100, 1, 32'h00400008, 32'h8C010000);
    tbl[9]  = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h20030003, M,   1, 32'h00400104, 1, 32'h00400100, 32'h20030003);
    tbl[10] = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'h20040004, M,   0, 32'h00400108, 1, 32'h00400104, 32'h20040004);
    tbl[11] = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'h00000000, M,   0, 32'h00400108, 0, 32'h00400104, 32'h00000000);
    tbl[12] = v(0, 1, 1, 32'h00400200,  0, 0, 32'h0, 0, 32'h00000000, M,   1, 32'h00400108, 0, 32'h00400104, 32'h00000000);
    tbl[13] = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h20050005, M,   1, 32'h00400200, 1, 32'h00400108, 32'h20050005);
    tbl[14] = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h8C020000, M,   0, 32'h00400204, 1, 32'h00400200, 32'h8C020000);
    tbl[15] = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h77777777, M,   0, 32'h00400204, 1, 32'h00400200, 32'h8C020000);
    tbl[16] = v(0, 0, 1, 32'h00400300,  1, 0, 32'h0, 0, 32'h66666666, M,   1, 32'h00400004, 0, 32'h00400200, 32'h8C020000);
    tbl[17] = v(0, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h3C010040, M,   1, 32'h00400008, 1, 32'h00400004, 32'h3C010040);
    tbl[18] = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0A0A0A0A, M,   0, 32'h0040000C, 1, 32'h00400008, 32'h0A0A0A0A);
    tbl[19] = v(1, 0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0B0B0B0B, MNA, 0, 32'h0,        0, 32'h00400008, 32'h0B0B0B0B);
    tbl[20] = v(0, 0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h00000000, M,   1, 32'h00400000, 0, 32'h00000000, 32'h00000000);

    for (int i = 0; i < 21; i++) apply(tbl[i], i);

    // Stall with imem_rdata randomised: the captured word must persist.
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 32'h8C010000, M, 0, 32'h00400004, 1, 32'h00400000, 32'h8C010000), 100);
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, r, M, 0, 32'h00400004, 1, 32'h00400000, 32'h8C010000), 101 + i);
    end
    r = $urandom;
    apply(v(0, 1, 0, 0, 0, 0, 0, 0, r, M, 1, 32'h00400004, 1, 32'h00400000, 32'h8C010000), 104);

    // Halt: one handoff, then nothing issued or presented; eret overrides halt.
    apply(v(0, 1, 0, 0, 0, 0, 0, 1, 32'h11112222, M, 0, 32'h00400008, 1, 32'h00400004, 32'h11112222), 200);
    for (int i = 0; i < 3; i++)
      apply(v(0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 5'h1E, 0, 32'h00400008, 0, 32'h00400004, 32'h0), 201 + i);
    apply(v(0, 1, 0, 0, 0, 1, 32'h00400040, 1, 32'h0, 5'h1C, 1, 32'h00400040, 0, 32'h0, 32'h0), 204);
    apply(v(0, 1, 0, 0, 0, 0, 0, 1, 32'h99990000, M, 0, 32'h00400044, 1, 32'h00400040, 32'h99990000), 205);

    // PC wrap past the top of the address space.
    apply(v(0, 1, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 5'h1C, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0), 300);
    apply(v(0, 1, 0, 0, 0, 0, 0, 0, 32'h12340000, M, 1, 32'h00000000, 1, 32'hFFFFFFFC, 32'h12340000), 301);

    t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(t, 999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
